// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  mem_port_arbiter -- shares one data-memory port between LDQ loads and SDQ
//  committed-store drain; one outstanding transaction, loads have priority.
//  Optional: `define MEM_ARB_PERF_EN adds load/store/stall perf counters.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int LDQ_ENTRIES  = 8,
  parameter int STARVE_LIMIT = 4,
  localparam int TAG_W = (LDQ_ENTRIES > 1) ? $clog2(LDQ_ENTRIES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             ld_req_vld_i,
  input  logic [31:0]      ld_req_addr_i,
  input  logic [TAG_W-1:0] ld_req_tag_i,
  output logic             ld_req_rdy_o,
  input  logic             st_req_vld_i,
  input  logic [31:0]      st_req_addr_i,
  input  logic [31:0]      st_req_data_i,
  input  logic [3:0]       st_req_be_i,
  input  logic             st_urgent_i,
  output logic             st_req_rdy_o,
  output logic             mem_req_vld_o,
  output logic             mem_req_we_o,
  output logic [31:0]      mem_req_addr_o,
  output logic [31:0]      mem_req_wdata_o,
  output logic [3:0]       mem_req_be_o,
  input  logic             mem_req_rdy_i,
  input  logic             mem_rsp_vld_i,
  input  logic [31:0]      mem_rsp_data_i,
  output logic             ld_rsp_vld_o,
  output logic [TAG_W-1:0] ld_rsp_tag_o,
  output logic [31:0]      ld_rsp_data_o,
  output logic             st_done_o,
  output logic             busy_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]      perf_ld_cnt_o,
  output logic [31:0]      perf_st_cnt_o,
  output logic [31:0]      perf_stall_cnt_o
`endif
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt, w_starve_nxt;
  logic              r_squash;
  logic              r_we;
  logic [31:0]       r_addr, r_wdata;
  logic [3:0]        r_be;
  logic [TAG_W-1:0]  r_tag;
  logic              r_ld_rsp_vld, r_st_done;
  logic [TAG_W-1:0]  r_ld_rsp_tag;
  logic [31:0]       r_ld_rsp_data;

  logic w_st_grant, w_ld_grant, w_ld_acc, w_st_acc, w_rsp_done, w_ld_ret;

  always_comb begin
    w_st_grant = st_req_vld_i &
                 (st_urgent_i | (r_starve_cnt >= C_LIMIT) | ~ld_req_vld_i);
    w_ld_grant = ld_req_vld_i & ~w_st_grant;
    // Accept strobes are forced low while reset is held so every output reads 0.
    w_ld_acc   = (r_state == IDLE) & w_ld_grant & ~flush_i & ~rst_i;
    w_st_acc   = (r_state == IDLE) & w_st_grant & ~rst_i;
    w_rsp_done = (r_state == WAIT_RSP) & mem_rsp_vld_i;
    w_ld_ret   = w_rsp_done & ~r_we & ~r_squash & ~flush_i;

    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_ld_acc | w_st_acc) w_state_nxt = REQ;
      REQ:      if (mem_req_rdy_i)       w_state_nxt = WAIT_RSP;
      WAIT_RSP: if (mem_rsp_vld_i)       w_state_nxt = IDLE;
      default:                           w_state_nxt = IDLE;
    endcase

    w_starve_nxt = r_starve_cnt;
    if (!st_req_vld_i || w_st_acc)
      w_starve_nxt = '0;
    else if ((r_state == IDLE) && w_ld_grant && (r_starve_cnt < C_LIMIT))
      w_starve_nxt = r_starve_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve_cnt  <= '0;
      r_squash      <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_be          <= '0;
      r_tag         <= '0;
      r_ld_rsp_vld  <= 1'b0;
      r_st_done     <= 1'b0;
      r_ld_rsp_tag  <= '0;
      r_ld_rsp_data <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      if (w_ld_acc) begin
        r_we    <= 1'b0;
        r_addr  <= ld_req_addr_i;
        r_wdata <= '0;
        r_be    <= 4'hF;
        r_tag   <= ld_req_tag_i;
      end else if (w_st_acc) begin
        r_we    <= 1'b1;
        r_addr  <= st_req_addr_i;
        r_wdata <= st_req_data_i;
        r_be    <= st_req_be_i;
      end
      // Squash lives only for the current load; cleared on the way back to IDLE.
      if (w_state_nxt == IDLE)
        r_squash <= 1'b0;
      else if (flush_i && !r_we && (r_state != IDLE))
        r_squash <= 1'b1;
      r_ld_rsp_vld <= w_ld_ret;
      r_st_done    <= w_rsp_done & r_we;
      if (w_ld_ret) begin
        r_ld_rsp_tag  <= r_tag;
        r_ld_rsp_data <= mem_rsp_data_i;
      end
    end
  end

  assign ld_req_rdy_o    = w_ld_acc;
  assign st_req_rdy_o    = w_st_acc;
  assign mem_req_vld_o   = (r_state == REQ);
  assign mem_req_we_o    = r_we;
  assign mem_req_addr_o  = r_addr;
  assign mem_req_wdata_o = r_wdata;
  assign mem_req_be_o    = r_be;
  assign ld_rsp_vld_o    = r_ld_rsp_vld;
  assign ld_rsp_tag_o    = r_ld_rsp_tag;
  assign ld_rsp_data_o   = r_ld_rsp_data;
  assign st_done_o       = r_st_done;
  assign busy_o          = (r_state != IDLE);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] r_perf_ld, r_perf_st, r_perf_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_ld    <= '0;
      r_perf_st    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_rsp_done && !r_we)                 r_perf_ld    <= r_perf_ld + 32'd1;
      if (w_rsp_done && r_we)                  r_perf_st    <= r_perf_st + 32'd1;
      if ((r_state == REQ) && !mem_req_rdy_i)  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_ld_cnt_o    = r_perf_ld;
  assign perf_st_cnt_o    = r_perf_st;
  assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  tb_mem_port_arbiter -- directed scoreboard bench for mem_port_arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic        ld_req_vld_i, st_req_vld_i, st_urgent_i, mem_req_rdy_i;
  logic [31:0] ld_req_addr_i, st_req_addr_i, st_req_data_i;
  logic [2:0]  ld_req_tag_i;
  logic [3:0]  st_req_be_i;
  logic        ld_req_rdy_o, st_req_rdy_o, mem_req_vld_o, mem_req_we_o;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o, ld_rsp_data_o;
  logic [3:0]  mem_req_be_o;
  wire         mem_rsp_vld_i;
  wire  [31:0] mem_rsp_data_i;
  logic        ld_rsp_vld_o, st_done_o, busy_o;
  logic [2:0]  ld_rsp_tag_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_ld_cnt_o, perf_st_cnt_o, perf_stall_cnt_o;
`endif

  logic        auto_vld = 1'b0, man_vld = 1'b0, auto_rsp = 1'b1;
  logic [31:0] auto_data = '0, man_data = '0, resp_addr, last_st_addr = '0;
  int          rsp_delay = 0;
  assign mem_rsp_vld_i  = auto_vld | man_vld;
  assign mem_rsp_data_i = man_vld ? man_data : auto_data;

  mem_port_arbiter #(.LDQ_ENTRIES(8), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .ld_req_vld_i(ld_req_vld_i), .ld_req_addr_i(ld_req_addr_i),
    .ld_req_tag_i(ld_req_tag_i), .ld_req_rdy_o(ld_req_rdy_o),
    .st_req_vld_i(st_req_vld_i), .st_req_addr_i(st_req_addr_i),
    .st_req_data_i(st_req_data_i), .st_req_be_i(st_req_be_i),
    .st_urgent_i(st_urgent_i), .st_req_rdy_o(st_req_rdy_o),
    .mem_req_vld_o(mem_req_vld_o), .mem_req_we_o(mem_req_we_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
    .mem_req_be_o(mem_req_be_o), .mem_req_rdy_i(mem_req_rdy_i),
    .mem_rsp_vld_i(mem_rsp_vld_i), .mem_rsp_data_i(mem_rsp_data_i),
    .ld_rsp_vld_o(ld_rsp_vld_o), .ld_rsp_tag_o(ld_rsp_tag_o),
    .ld_rsp_data_o(ld_rsp_data_o), .st_done_o(st_done_o), .busy_o(busy_o)
`ifdef MEM_ARB_PERF_EN
    , .perf_ld_cnt_o(perf_ld_cnt_o), .perf_st_cnt_o(perf_st_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } req_t;
  typedef struct { logic [2:0] tag; logic [31:0] data; } ldr_t;
  req_t        exp_req[$];
  ldr_t        exp_ld[$];
  logic [31:0] exp_st[$];
  int n_cmp = 0, n_fail = 0, n_ld_rsp = 0, ld_acc_cyc = 0, last_ld_cyc = 0;

  // Memory contents as seen by the responder.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++; n_fail++;
    $display("FAIL %s: unexpected/timeout at cycle %0d", name, cyc);
  endtask

  task automatic push_ld(input logic [31:0] a, input logic [2:0] t);
    req_t r; ldr_t l;
    r.we = 1'b0; r.addr = a; r.wdata = '0; r.be = 4'hF;
    l.tag = t; l.data = mem_data(a);
    exp_req.push_back(r); exp_ld.push_back(l);
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_t r;
    r.we = 1'b1; r.addr = a; r.wdata = d; r.be = be;
    exp_req.push_back(r); exp_st.push_back(a);
  endtask

  task automatic drive_load(input logic [31:0] a, input logic [2:0] t);
    bit ok = 0;
    ld_req_vld_i = 1'b1; ld_req_addr_i = a; ld_req_tag_i = t;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_i);
      if (ld_req_rdy_o) begin ok = 1; ld_acc_cyc = cyc; end
    end
    if (!ok) bad("ld_accept");
    @(posedge clk_i); #1;
    ld_req_vld_i = 1'b0;
  endtask

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic urg);
    bit ok = 0;
    st_req_vld_i = 1'b1; st_req_addr_i = a; st_req_data_i = d;
    st_req_be_i = be; st_urgent_i = urg;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk_i);
      if (st_req_rdy_o) ok = 1;
    end
    if (!ok) bad("st_accept");
    @(posedge clk_i); #1;
    st_req_vld_i = 1'b0; st_urgent_i = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_i);
      if (!busy_o && exp_req.size() == 0 && exp_ld.size() == 0 && exp_st.size() == 0)
        ok = 1;
    end
    if (!ok) bad("drain");
    @(posedge clk_i); #1;
  endtask

  // Memory responder: acks each accepted request after rsp_delay extra cycles.
  initial begin
    forever begin
      @(negedge clk_i);
      if (auto_rsp && !rst_i && mem_req_vld_o && mem_req_rdy_i) begin
        resp_addr = mem_req_addr_o;
        @(posedge clk_i);
        repeat (rsp_delay) @(posedge clk_i);
        #1; auto_vld = 1'b1; auto_data = mem_data(resp_addr);
        @(posedge clk_i); #1; auto_vld = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    req_t r; ldr_t l; logic [31:0] sa;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (mem_req_vld_o && mem_req_rdy_i) begin
          if (exp_req.size() == 0) bad("mem_req_extra");
          else begin
            r = exp_req.pop_front();
            chk("mem_we", {31'd0, mem_req_we_o}, {31'd0, r.we});
            chk("mem_addr", mem_req_addr_o, r.addr);
            chk("mem_be", {28'd0, mem_req_be_o}, {28'd0, r.be});
            if (r.we) chk("mem_wdata", mem_req_wdata_o, r.wdata);
          end
          if (mem_req_we_o) last_st_addr = mem_req_addr_o;
        end
        if (ld_rsp_vld_o) begin
          n_ld_rsp++; last_ld_cyc = cyc;
          if (exp_ld.size() == 0) bad("ld_rsp_extra");
          else begin
            l = exp_ld.pop_front();
            chk("ld_rsp_tag", {29'd0, ld_rsp_tag_o}, {29'd0, l.tag});
            chk("ld_rsp_data", ld_rsp_data_o, l.data);
          end
        end
        if (st_done_o) begin
          if (exp_st.size() == 0) bad("st_done_extra");
          else begin
            sa = exp_st.pop_front();
            chk("st_done_addr", last_st_addr, sa);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_i = 1'b1; flush_i = 1'b0; mem_req_rdy_i = 1'b1;
    ld_req_vld_i = 1'b1; ld_req_addr_i = 32'h100; ld_req_tag_i = 3'd1;
    st_req_vld_i = 1'b1; st_req_addr_i = 32'h80; st_req_data_i = 32'h1;
    st_req_be_i = 4'hF; st_urgent_i = 1'b1;

    // Reset state: every output low even with requests pending.
    repeat (2) @(negedge clk_i);
    chk("rst_ctrl", {25'd0, ld_req_rdy_o, st_req_rdy_o, mem_req_vld_o, mem_req_we_o,
                     ld_rsp_vld_o, st_done_o, busy_o}, 32'd0);
    chk("rst_addr", mem_req_addr_o, 32'd0);
    chk("rst_wdata", mem_req_wdata_o, 32'd0);
    chk("rst_be_tag", {25'd0, mem_req_be_o, ld_rsp_tag_o}, 32'd0);
    chk("rst_ld_data", ld_rsp_data_o, 32'd0);
    ld_req_vld_i = 1'b0; st_req_vld_i = 1'b0; st_urgent_i = 1'b0;
    @(posedge clk_i); #1; rst_i = 1'b0;

    // Load only, minimum turnaround.
    push_ld(32'h100, 3'd3);
    drive_load(32'h100, 3'd3);
    drain();
    chk("ld_latency", last_ld_cyc - ld_acc_cyc, 32'd3);

    // Continuous contention: four loads, then the starved store; twice.
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) push_ld(32'h1000 + 32'(k * 64 + j * 4), 3'(j));
      push_st(32'h2000 + 32'(k * 16), 32'hA0A0_0000 + 32'(k), 4'hC);
      push_ld(32'h1000 + 32'(k * 64 + 16), 3'd4);
      fork
        for (int j = 0; j < 5; j++) drive_load(32'h1000 + 32'(k * 64 + j * 4), 3'(j));
        drive_store(32'h2000 + 32'(k * 16), 32'hA0A0_0000 + 32'(k), 4'hC, 1'b0);
      join
      drain();
    end

    // Urgent store beats a concurrent load.
    push_st(32'h400, 32'hCAFEF00D, 4'b0110);
    push_ld(32'h440, 3'd7);
    fork
      drive_store(32'h400, 32'hCAFEF00D, 4'b0110, 1'b1);
      drive_load(32'h440, 3'd7);
    join
    drain();

    // Flush while the load waits for its response.
    rsp_delay = 2;
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h200; r.wdata = '0; r.be = 4'hF;
      exp_req.push_back(r);
    end
    n0 = n_ld_rsp;
    drive_load(32'h200, 3'd5);
    @(posedge clk_i); #1; flush_i = 1'b1;
    @(posedge clk_i); #1; flush_i = 1'b0;
    drain();
    repeat (3) @(negedge clk_i);
    chk("flush_no_rsp", 32'(n_ld_rsp - n0), 32'd0);
    rsp_delay = 0;
    @(posedge clk_i); #1;
    push_ld(32'h240, 3'd6);
    drive_load(32'h240, 3'd6);
    drain();

    // Memory back-pressure: request and payload held, no new accept.
    mem_req_rdy_i = 1'b0;
    push_ld(32'h300, 3'd1);
    drive_load(32'h300, 3'd1);
    ld_req_vld_i = 1'b1; ld_req_addr_i = 32'h340; ld_req_tag_i = 3'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stall_vld_busy", {30'd0, mem_req_vld_o, busy_o}, 32'd3);
      chk("stall_addr", mem_req_addr_o, 32'h300);
      chk("stall_be_we", {27'd0, mem_req_be_o, mem_req_we_o}, 32'h1E);
      chk("stall_ld_rdy", {31'd0, ld_req_rdy_o}, 32'd0);
    end
    @(posedge clk_i); #1; mem_req_rdy_i = 1'b1;
    push_ld(32'h340, 3'd2);
    drive_load(32'h340, 3'd2);
    drain();

    // Asynchronous reset in WAIT_RSP, then a stray response.
    auto_rsp = 1'b0;
    begin
      req_t r;
      r.we = 1'b0; r.addr = 32'h500; r.wdata = '0; r.be = 4'hF;
      exp_req.push_back(r);
    end
    n0 = n_ld_rsp;
    drive_load(32'h500, 3'd4);
    @(posedge clk_i); #3;
    chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    chk("async_rst_ctrl", {28'd0, busy_o, mem_req_vld_o, ld_rsp_vld_o, st_done_o}, 32'd0);
    chk("async_rst_addr", mem_req_addr_o, 32'd0);
    chk("async_rst_be", {28'd0, mem_req_be_o}, 32'd0);
    @(posedge clk_i); #1; rst_i = 1'b0;
    man_vld = 1'b1; man_data = 32'h12345678;
    @(posedge clk_i); #1; man_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("stray_rsp_ign", {30'd0, busy_o, ld_rsp_vld_o}, 32'd0);
    end
    chk("stray_no_rsp", 32'(n_ld_rsp - n0), 32'd0);
    auto_rsp = 1'b1;
    @(posedge clk_i); #1;
    push_ld(32'h100, 3'd0);
    drive_load(32'h100, 3'd0);
    drain();

    chk("q_req_empty", 32'(exp_req.size()), 32'd0);
    chk("q_ld_empty", 32'(exp_ld.size()), 32'd0);
    chk("q_st_empty", 32'(exp_st.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
